// File: rtl/fwd_track_unit.sv
// EX-operand forwarding with a private shift-register record of in-flight producers.
// Optional FWD_TRACK_STATS_EN adds saturating forward-hit and stall counters.

module fwd_track_lookup #(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 1,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic [REG_AW-1:0]             rs_i,
    input  logic [DATA_W-1:0]             rf_data_i,
    input  logic [DEPTH-1:0]              rec_v_i,
    input  logic [DEPTH-1:0]              rec_rdy_i,
    input  logic [DEPTH-1:0][REG_AW-1:0]  rec_rd_i,
    input  logic [DEPTH-1:0][DATA_W-1:0]  rec_data_i,
    input  logic                          load_data_valid_i,
    input  logic [DATA_W-1:0]             load_data_i,
    output logic [DATA_W-1:0]             op_o,
    output logic [SEL_W-1:0]              sel_o,
    output logic                          stall_o
);
    logic w_hit;
    int   w_idx;

    always_comb begin
        w_hit   = 1'b0;
        w_idx   = 0;
        op_o    = rf_data_i;
        sel_o   = '0;
        stall_o = 1'b0;
        // Youngest match wins, even when it is not ready yet.
        for (int k = 0; k < DEPTH; k++) begin
            if (!w_hit && rec_v_i[k] && rec_rd_i[k] == rs_i) begin
                w_hit = 1'b1;
                w_idx = k;
            end
        end
        if (rs_i != '0 && w_hit) begin
            if (rec_rdy_i[w_idx]) begin
                op_o  = rec_data_i[w_idx];
                sel_o = SEL_W'(w_idx + 1);
            end else if (w_idx == LOAD_STAGE && load_data_valid_i) begin
                op_o  = load_data_i;
                sel_o = SEL_W'(w_idx + 1);
            end else begin
                stall_o = 1'b1;
            end
        end
    end
endmodule

module fwd_track_unit #(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int DEPTH      = 3,
    parameter int NUM_SRC    = 2,
    parameter int LOAD_STAGE = 1,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        hold_i,
    input  logic                        flush_i,
    input  logic                        push_valid_i,
    input  logic [REG_AW-1:0]           push_rd_i,
    input  logic [DATA_W-1:0]           push_data_i,
    input  logic                        push_is_load_i,
    input  logic                        load_data_valid_i,
    input  logic [DATA_W-1:0]           load_data_i,
    input  logic [NUM_SRC*REG_AW-1:0]   rs_addr_i,
    input  logic [NUM_SRC*DATA_W-1:0]   rf_data_i,
    output logic [NUM_SRC*DATA_W-1:0]   op_data_o,
    output logic [NUM_SRC*SEL_W-1:0]    fwd_sel_o,
    output logic                        stall_o,
    output logic [31:0]                 fwd_hit_cnt_o,
    output logic [31:0]                 stall_cnt_o
);
    // When the load stage is the last record, a fill on shift leaves with the record.
    localparam bit FILL_KEEP = (LOAD_STAGE + 1 < DEPTH);
    localparam int FILL_SH   = FILL_KEEP ? LOAD_STAGE + 1 : LOAD_STAGE;

    logic [DEPTH-1:0]             r_v;
    logic [DEPTH-1:0]             r_rdy;
    logic [DEPTH-1:0][REG_AW-1:0] r_rd;
    logic [DEPTH-1:0][DATA_W-1:0] r_data;

    logic [NUM_SRC-1:0][SEL_W-1:0] w_sel;
    logic [NUM_SRC-1:0]            w_stall;
    logic                          w_fill;

    assign w_fill = load_data_valid_i && r_v[LOAD_STAGE] && !r_rdy[LOAD_STAGE];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_v    <= '0;
            r_rdy  <= '0;
            r_rd   <= '0;
            r_data <= '0;
        end else if (flush_i) begin
            r_v <= '0;
        end else if (!hold_i) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                r_v[k]    <= r_v[k-1];
                r_rdy[k]  <= r_rdy[k-1];
                r_rd[k]   <= r_rd[k-1];
                r_data[k] <= r_data[k-1];
            end
            r_v[0]    <= push_valid_i && (push_rd_i != '0);
            r_rd[0]   <= push_rd_i;
            r_data[0] <= push_data_i;
            r_rdy[0]  <= !push_is_load_i;
            if (FILL_KEEP && w_fill) begin
                r_data[FILL_SH] <= load_data_i;
                r_rdy[FILL_SH]  <= 1'b1;
            end
        end else if (w_fill) begin
            r_data[LOAD_STAGE] <= load_data_i;
            r_rdy[LOAD_STAGE]  <= 1'b1;
        end
    end

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        fwd_track_lookup #(
            .DATA_W     (DATA_W),
            .REG_AW     (REG_AW),
            .DEPTH      (DEPTH),
            .LOAD_STAGE (LOAD_STAGE),
            .SEL_W      (SEL_W)
        ) u_lk (
            .rs_i              (rs_addr_i[s*REG_AW +: REG_AW]),
            .rf_data_i         (rf_data_i[s*DATA_W +: DATA_W]),
            .rec_v_i           (r_v),
            .rec_rdy_i         (r_rdy),
            .rec_rd_i          (r_rd),
            .rec_data_i        (r_data),
            .load_data_valid_i (load_data_valid_i),
            .load_data_i       (load_data_i),
            .op_o              (op_data_o[s*DATA_W +: DATA_W]),
            .sel_o             (w_sel[s]),
            .stall_o           (w_stall[s])
        );
    end

    assign fwd_sel_o = w_sel;
    assign stall_o   = |w_stall;

`ifdef FWD_TRACK_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_stall_cnt;
    logic [31:0] w_nhit;
    logic [32:0] w_hit_sum;

    always_comb begin
        w_nhit = '0;
        for (int s = 0; s < NUM_SRC; s++)
            if (w_sel[s] != '0) w_nhit = w_nhit + 32'd1;
    end

    assign w_hit_sum = {1'b0, r_hit_cnt} + {1'b0, w_nhit};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_hit_cnt   <= '0;
            r_stall_cnt <= '0;
        end else if (!hold_i && !flush_i) begin
            r_hit_cnt <= w_hit_sum[32] ? '1 : w_hit_sum[31:0];
            if (stall_o && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign fwd_hit_cnt_o = r_hit_cnt;
    assign stall_cnt_o   = r_stall_cnt;
`else
    assign fwd_hit_cnt_o = '0;
    assign stall_cnt_o   = '0;
`endif
endmodule

// File: doc/fwd_track_unit.md
Name: fwd_track_unit

Overview:
- Parametrised successor to the fixed 4:1 EX-operand forwarding mux.
- Keeps its own shift-register record of in-flight producers (destination register, result, ready flag) for DEPTH post-EX stages.
- Forwards the youngest matching result to each of NUM_SRC source operands and raises load-use stall when that producer's data is not yet available.
- Sits between ID/EX operand read and ALU input; replaces external forwarding-select logic.

Parameters:
- DATA_W, 32, operand/result width.
- REG_AW, 5, register address width.
- DEPTH, 3, number of tracked producer stages (>=2).
- NUM_SRC, 2, number of source operands looked up in parallel.
- LOAD_STAGE, 1, record index where load data returns (0 <= LOAD_STAGE < DEPTH).
- SEL_W, $clog2(DEPTH+1), width of a per-source select code.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- hold_i  in  1  freeze whole pipe; records do not shift.
- flush_i  in  1  invalidate all records.
- push_valid_i  in  1  EX-stage instruction writes a register.
- push_rd_i  in  REG_AW  EX-stage destination register.
- push_data_i  in  DATA_W  EX-stage ALU result.
- push_is_load_i  in  1  EX-stage result is a load; data not yet known.
- load_data_valid_i  in  1  load data for record LOAD_STAGE present this cycle.
- load_data_i  in  DATA_W  returned load data.
- rs_addr_i  in  NUM_SRC*REG_AW  source register addresses; source s at slice s.
- rf_data_i  in  NUM_SRC*DATA_W  register-file read data per source.
- op_data_o  out  NUM_SRC*DATA_W  resolved operand per source.
- fwd_sel_o  out  NUM_SRC*SEL_W  0 = register file; k+1 = record k.
- stall_o  out  1  load-use hazard; upstream must stall ID and inject a bubble.

Behaviour:
- State per record k: rec_v, rec_rd, rec_data, rec_rdy. Record 0 is youngest.
- Reset (rst_i low, async): all rec_v = 0.
  - Outputs then follow the empty-table rule: op_data_o = rf_data_i, fwd_sel_o = 0, stall_o = 0.
- Clock edge, priority order:
  1. flush_i: all rec_v <= 0. Wins over hold, push and fill.
  2. hold_i = 0 (shift):
     - rec[k] <= rec[k-1] for k >= 1.
     - rec[0] <= {push_valid_i && push_rd_i != 0, push_rd_i, push_data_i, !push_is_load_i}.
     - Record leaving index DEPTH-1 is discarded.
  3. hold_i = 1: records keep their position.
- Load fill:
  - Condition: load_data_valid_i and rec_v[LOAD_STAGE] and !rec_rdy[LOAD_STAGE].
  - Effect: the record is written with data = load_data_i, rdy = 1.
  - Applies in place on hold, or to its shifted position LOAD_STAGE+1 on shift.
  - Fill when LOAD_STAGE = DEPTH-1 and shifting: data is discarded with the record.
  - load_data_valid_i with no pending load at LOAD_STAGE: ignored.
- Lookup (combinational, per source s):
  - rs = 0: rf_data, sel 0, no stall.
  - Otherwise find the smallest k with rec_v[k] && rec_rd[k] == rs:
    - No match: rf_data, sel 0.
    - Match and rec_rdy: rec_data[k], sel k+1.
    - Match, !rec_rdy, k == LOAD_STAGE, load_data_valid_i: load_data_i, sel k+1 (same-cycle bypass, no stall).
    - Match, !rec_rdy otherwise: stall_o contribution 1; op_data = rf_data, sel 0.
  - Older matches are never used when a younger match exists, even if the younger one is not ready.
- stall_o = OR over sources. The unit does not gate push itself; upstream must push a bubble (push_valid_i = 0) during stall.
- Latency: operand resolution is 0 cycles; a result is forwardable the cycle after its push.

Optional Feature:
- Macro: FWD_TRACK_STATS_EN.
- Defined:
  - Adds outputs fwd_hit_cnt_o[31:0] and stall_cnt_o[31:0], reset to 0.
  - When hold_i = 0 and flush_i = 0: hit count += number of sources with sel != 0; stall count += 1 if stall_o.
  - Both counters saturate at 32'hFFFFFFFF.
- Undefined: both ports exist and are tied to 0; no counter flops.

Test Plan:
- Reset with rs = {3, 4}, rf_data = {0x11, 0x22} -> op = {0x11, 0x22}, sel = 0, stall = 0. Repeat mid-stream with full records -> same.
- Push rd = 3 data 0xAAAA, next cycle push rd = 3 data 0xBBBB, then rs0 = 3 -> op0 = 0xBBBB, sel0 = 1. One more cycle with a bubble pushed -> op0 = 0xBBBB, sel0 = 2.
- Push load rd = 5, then rs1 = 5 -> stall = 1, sel1 = 0. Next cycle (bubble pushed) with load_data_valid_i, data 0x1234 -> op1 = 0x1234, sel1 = 2, stall = 0. Following cycle -> op1 = 0x1234 from the filled record, sel1 = 3.
- Push rd = 0 data 0xFFFF, rs0 = 0, rf = 0 -> op0 = 0, sel0 = 0.
- Fill records for rd = 7, assert hold_i 3 cycles -> sel unchanged. Then flush_i with hold_i -> next cycle sel = 0 for rs = 7.
- With FWD_TRACK_STATS_EN: 4 cycles of 2 forwarded sources plus 1 stall cycle -> fwd_hit_cnt_o = 8, stall_cnt_o = 1.
